// File: rtl/capture_pkg.sv
// Shared constants and FSM state encoding for the capture-stage phase-recovery control path.
package capture_pkg;

    localparam int CAP_RATIO  = 12;
    localparam int CAP_RMAX   = CAP_RATIO - 1;
    localparam int CAP_RBITS  = 4;
    localparam int CAP_SETTLE = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_MEASURE = 3'd2,
        ST_WRITE   = 3'd3,
        ST_NEXT    = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

endpackage

// File: rtl/phase_match.sv
// Holds the candidate phase and counts consecutive matching samples; lock_o flags the locking sample.
// PHASE_SCAN_DRIFT_EN: a sample within +/-1 (mod ratio) of the held phase also counts as a match.
module phase_match
    import capture_pkg::*;
#(
    parameter int RBITS = CAP_RBITS,
    parameter int RMAX  = CAP_RMAX,
    parameter int LOCKS = 3
) (
    input  logic             clk_s_i,
    input  logic             reset_i,
    input  logic             clear_i,
    input  logic             stb_i,
    input  logic [RBITS-1:0] phase_i,
    output logic [RBITS-1:0] held_o,
    output logic             lock_o
);

    localparam int MBITS = $clog2(LOCKS + 1);

    logic [MBITS-1:0] match_q, match_n;
    logic [RBITS-1:0] held_q;
    logic             in_range, same, load;

    // Out-of-range phases never match, so they always restart the run.
    assign in_range = (phase_i <= RBITS'(RMAX)) && (held_q <= RBITS'(RMAX));

`ifdef PHASE_SCAN_DRIFT_EN
    logic [RBITS-1:0] held_up, held_dn;
    assign held_up = (held_q == RBITS'(RMAX)) ? '0 : held_q + RBITS'(1);
    assign held_dn = (held_q == '0) ? RBITS'(RMAX) : held_q - RBITS'(1);
    assign same    = in_range && ((phase_i == held_q) || (phase_i == held_up) || (phase_i == held_dn));
`else
    assign same    = in_range && (phase_i == held_q);
`endif

    assign load = !clear_i && stb_i && !((match_q != '0) && same);

    always_comb begin
        match_n = match_q;
        if (clear_i) begin
            match_n = '0;
        end else if (stb_i) begin
            if ((match_q != '0) && same)
                match_n = (match_q == MBITS'(LOCKS)) ? match_q : match_q + MBITS'(1);
            else
                match_n = MBITS'(1);
        end
    end

    always_ff @(posedge clk_s_i or posedge reset_i) begin
        if (reset_i) begin
            match_q <= '0;
            held_q  <= '0;
        end else begin
            match_q <= match_n;
            if (load)
                held_q <= phase_i;
        end
    end

    assign held_o = held_q;
    assign lock_o = !clear_i && stb_i && (match_n == MBITS'(LOCKS));

endmodule

// File: rtl/phase_scan_ctrl.sv
// Scans every source through the phase-recovery unit and records locked phases / timeouts.
// Optional PHASE_SCAN_DRIFT_EN (in phase_match) accepts +/-1 phase drift as a match.
module phase_scan_ctrl
    import capture_pkg::*;
#(
    parameter int WIDTH  = 24,
    parameter int SBITS  = 5,
    parameter int RBITS  = CAP_RBITS,
    parameter int RMAX   = CAP_RMAX,
    parameter int LOCKS  = 3,
    parameter int SETTLE = CAP_SETTLE,
    parameter int TBITS  = 12
) (
    input  logic             clk_s_i,
    input  logic             reset_i,
    input  logic             scan_i,
    input  logic             abort_i,
    output logic             align_o,
    output logic [SBITS-1:0] select_o,
    output logic             retry_o,
    input  logic             stb_i,
    input  logic [RBITS-1:0] phase_i,
    input  logic             error_i,
    output logic             wr_o,
    output logic [SBITS-1:0] wr_adr_o,
    output logic [RBITS-1:0] wr_dat_o,
    output logic [WIDTH-1:0] fail_o,
    output logic             busy_o,
    output logic             done_o,
    output state_t           state_o
);

    localparam int SCW = $clog2(SETTLE + 1);

    state_t           state_q, state_n;
    logic [SBITS-1:0] select_q;
    logic [WIDTH-1:0] fail_q;
    logic [SCW-1:0]   settle_q;
    logic [TBITS-1:0] tmo_q;
    logic             err_seen_q;
    logic             err_act, lock, scan_go, sel_inc, set_fail;
    logic [RBITS-1:0] held;

    // stb_i is a valid-only strobe: the phase unit has no backpressure, every strobe in MEASURE is consumed.
    assign err_act = (state_q == ST_MEASURE) && error_i && !err_seen_q;

    phase_match #(
        .RBITS (RBITS),
        .RMAX  (RMAX),
        .LOCKS (LOCKS)
    ) u_match (
        .clk_s_i (clk_s_i),
        .reset_i (reset_i),
        .clear_i ((state_q != ST_MEASURE) || err_act),
        .stb_i   (stb_i),
        .phase_i (phase_i),
        .held_o  (held),
        .lock_o  (lock)
    );

    always_comb begin
        state_n  = state_q;
        scan_go  = 1'b0;
        sel_inc  = 1'b0;
        set_fail = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (scan_i) begin
                    scan_go = 1'b1;
                    state_n = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_q == SCW'(SETTLE - 1))
                    state_n = ST_MEASURE;
            end
            ST_MEASURE: begin
                if (lock) begin
                    state_n = ST_WRITE;
                end else if (tmo_q == '1) begin
                    set_fail = 1'b1;
                    state_n  = ST_NEXT;
                end
            end
            ST_WRITE: state_n = ST_NEXT;
            ST_NEXT: begin
                if (select_q == SBITS'(WIDTH - 1)) begin
                    state_n = ST_DONE;
                end else begin
                    sel_inc = 1'b1;
                    state_n = ST_SETTLE;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
        if (abort_i && (state_q != ST_IDLE)) begin
            state_n  = ST_IDLE;
            sel_inc  = 1'b0;
            set_fail = 1'b0;
        end
    end

    always_ff @(posedge clk_s_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            select_q   <= '0;
            fail_q     <= '0;
            settle_q   <= '0;
            tmo_q      <= '0;
            err_seen_q <= 1'b0;
        end else begin
            state_q    <= state_n;
            err_seen_q <= (state_q == ST_MEASURE) && error_i;
            settle_q   <= ((state_q == ST_SETTLE) && (state_n == ST_SETTLE)) ? settle_q + SCW'(1) : '0;
            tmo_q      <= ((state_q == ST_MEASURE) && (state_n == ST_MEASURE)) ? tmo_q + TBITS'(1) : '0;
            if (scan_go) begin
                select_q <= '0;
                fail_q   <= '0;
            end else begin
                if (sel_inc)
                    select_q <= select_q + SBITS'(1);
                if (set_fail)
                    fail_q <= fail_q | (WIDTH'(1) << select_q);
            end
        end
    end

    assign align_o  = (state_q == ST_MEASURE);
    assign busy_o   = (state_q != ST_IDLE);
    assign wr_o     = (state_q == ST_WRITE);
    assign done_o   = (state_q == ST_DONE);
    assign retry_o  = err_act;
    assign select_o = select_q;
    assign wr_adr_o = wr_o ? select_q : '0;
    assign wr_dat_o = wr_o ? held : '0;
    assign fail_o   = fail_q;
    assign state_o  = state_q;

endmodule

// File: doc/phase_scan_ctrl.md
Name: phase_scan_ctrl

Overview:
- Sequencer for the capture-stage phase-recovery datapath.
- Steps the source select through all WIDTH antenna signals and enables alignment on each one.
- Watches the recovered phase until it holds steady for LOCKS consecutive data-clock strobes, then writes the locked phase into a per-channel phase table.
- Channels that never lock are flagged in a fail bitmap. Sits between the SPI register block (start/abort, status) and the phase-recovery unit.

Parameters:
- WIDTH, 24, number of signal sources scanned.
- SBITS, 5, select/table-address width (2^SBITS >= WIDTH).
- RBITS, 4, phase width (sampling:data ratio 12, phases 0..RMAX).
- RMAX, 11, maximum phase value (ratio-1).
- LOCKS, 3, consecutive identical phase samples needed for lock.
- SETTLE, 4, clk_s_i cycles waited after a select change (two MUX stages plus synchronisers).
- TBITS, 12, timeout counter width; timeout = 2^TBITS-1 cycles per channel.

Ports:
- clk_s_i  in  1  sampling clock, the only clock.
- reset_i  in  1  asynchronous, active-high reset.
- scan_i  in  1  start-scan strobe (one cycle).
- abort_i  in  1  abandon scan, return to IDLE.
- align_o  out  1  phase-unit enable.
- select_o  out  SBITS  phase-unit source select.
- retry_o  out  1  one-cycle acknowledge of phase-unit error.
- stb_i  in  1  phase-unit new-sample strobe.
- phase_i  in  RBITS  recovered phase.
- error_i  in  1  phase-unit lock-lost flag.
- wr_o  out  1  phase-table write strobe.
- wr_adr_o  out  SBITS  table address (channel).
- wr_dat_o  out  RBITS  locked phase.
- fail_o  out  WIDTH  bit n set = channel n timed out.
- busy_o  out  1  scan in progress.
- done_o  out  1  one-cycle strobe at scan completion.

Behaviour:

Reset values:
- All outputs 0; state IDLE; internal counters 0.
- fail_o holds its value until the next scan_i accepted in IDLE, which clears it.

FSM states: IDLE, SETTLE, MEASURE, WRITE, NEXT, DONE.
- IDLE: busy_o=0, align_o=0. When scan_i=1: select_o<=0, fail_o<=0, go to SETTLE. scan_i is ignored in every other state.
- SETTLE: align_o=0, busy_o=1. Count SETTLE cycles, then go to MEASURE with align_o=1.
- MEASURE: align_o=1. On each stb_i:
  - phase_i == held phase: match counter increments, saturating at LOCKS.
  - otherwise: held phase <= phase_i and match counter = 1.
  - The first stb_i after entering MEASURE always loads the held phase with match = 1.
  - When match reaches LOCKS, go to WRITE.
- error_i in MEASURE: pulse retry_o for one cycle, clear match to 0. error_i is not acted on again until it deasserts.
- Timeout: counter is cleared on entry to MEASURE and increments every cycle. On reaching all-ones, set fail_o[select_o], write nothing, go to NEXT.
- WRITE: single cycle; wr_o=1, wr_adr_o=select_o, wr_dat_o=held phase. Then NEXT.
- NEXT: align_o=0.
  - select_o == WIDTH-1: go to DONE.
  - otherwise: select_o <= select_o+1, go to SETTLE.
- DONE: done_o=1 for one cycle, then IDLE.

Boundary and priority rules:
- stb_i and error_i in the same cycle: error wins (match cleared, sample discarded).
- Lock reached in the same cycle as timeout: lock wins (WRITE, no fail bit set).
- abort_i in any non-IDLE state: next cycle is IDLE, align_o=0, no wr_o or done_o. fail_o keeps its partial contents.
- reset_i mid-scan: everything returns immediately to reset values.

Widths and latency:
- phase_i values > RMAX are treated as non-matching, so they restart the match at 1.
- Minimum latency per locked channel = SETTLE + LOCKS strobes + 2 cycles (WRITE, NEXT).

Optional Feature:
- PHASE_SCAN_DRIFT_EN defined: a sample also counts as matching if it differs from the held phase by ±1 modulo RATIO (i.e. 0 and RMAX are adjacent). The held phase is not updated on a ±1 match, so the written value is the first phase of the run.
- Undefined: exact equality only.

Decomposition:
- Shared package `capture_pkg`:
  - FSM state encoding (localparams ST_IDLE..ST_DONE);
  - RATIO/RMAX/RBITS constants;
  - SETTLE default.
- One natural sub-module, `phase_match`: holds the phase register and match counter (plus the DRIFT_EN comparison), and outputs a lock flag. The FSM stays in phase_scan_ctrl.

Test Plan:
- WIDTH=4, phase_i constant 7 on every stb_i, scan_i pulse -> four wr_o pulses with adr 0,1,2,3, dat 7; done_o once; fail_o=0.
- Channel 2 phase sequence 3,4,4,4 -> single write adr 2, dat 4, issued on the third matching strobe.
- Channel 1 stb_i never asserted -> after 4095 cycles fail_o=4'b0010, no write to adr 1, scan continues to channel 2.
- error_i during MEASURE after two matches -> retry_o one-cycle pulse, match restarts, three further matches needed before the write.
- abort_i while on channel 2 -> IDLE next cycle, align_o=0, no done_o; then reset_i mid-SETTLE -> all outputs 0.
- With PHASE_SCAN_DRIFT_EN, sequence 11,0,11 -> lock, dat 11; without the macro, the same sequence gives no lock.
